ux_dequant_expand_pipe: RTL and testbench
=========================================

Name: ux_dequant_expand_pipe

Overview:
- Inverse-direction companion to the rounding blocks: takes a narrowed (rounded) signed word and re-expands it to full WordLength by appending RoundLength fraction bits.
- Fill is selected per transfer: zeros, mid-point (half-LSB reconstruction), or LFSR dither.
- Sits on the input side of wide-precision datapaths that consume rounded streams.
- Valid/ready handshaked, one register stage plus skid buffer so in_ready is registered.

Parameters:
- WordLength, 32, width of expanded output word.
- RoundLength, 16, number of fraction bits restored; legal range 2..16.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  synchronous, active-low reset.
- CE  input  1  clock enable; 0 freezes all state.
- in_valid  input  1  x/mode valid.
- in_ready  output  1  registered; block can accept.
- x  input  WordLength-RoundLength  signed narrowed word.
- mode  input  2  0=zero fill, 1=mid-point, 2=dither, 3=reserved (treated as 0).
- out_valid  output  1  y valid.
- out_ready  input  1  downstream accepts.
- y  output  WordLength  signed expanded word.

Behaviour:
- Reset (RESET=0 at a clock edge, CE ignored):
  - out_valid=0, y=0, skid empty, in_ready=1.
  - LFSR=16'hACE1.
  - Reset mid-transfer discards the output and skid contents with no flush.
- Transfer definitions:
  - Input transfer: CE && in_valid && in_ready at a clock edge.
  - Output transfer: CE && out_valid && out_ready at a clock edge.
- CE=0 behaviour:
  - No state changes, LFSR holds.
  - in_ready and out_valid are masked to 0 at the ports; internal values are held.
- Expansion (computed on the input side, registered):
  - y = {x, F}; upper WordLength-RoundLength bits are x unchanged. Sign is preserved by construction, so no saturation is possible.
  - mode 0/3: F = 0.
  - mode 1: F = 1 followed by RoundLength-1 zeros.
  - mode 2: F = LFSR[RoundLength-1:0], using the LFSR value before the step.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - fb = L[0]^L[2]^L[3]^L[5]; L <= {fb, L[15:1]}.
  - Steps once per input transfer regardless of mode; otherwise holds.
- Latency: 1 cycle. A word accepted at edge N appears with out_valid=1 after edge N if the output register is free.
- Output register loading:
  - If the output register is empty, or out_ready is high this cycle, an accepted word loads the output register directly.
  - If the output register is full and not draining, the accepted word goes to the skid; in_ready=0 from the next cycle.
- Skid full:
  - in_ready=0.
  - On the next output transfer, the skid word moves to the output register (out_valid stays 1); skid becomes empty; in_ready=1 the following cycle.
- Simultaneous accept and drain with skid empty: the new word replaces the output directly; no bubble.
- Ordering: strictly FIFO. No word is dropped or duplicated. Maximum occupancy is 2.
- Output stability: y held stable while out_valid && !out_ready.

Test Plan:
- Reset, then x=16'h1234, mode=0, out_ready=1 -> one cycle later out_valid=1, y=32'h12340000; in_ready stays 1.
- x=16'h1234 mode=1 -> y=32'h12348000. x=16'h8000 mode=1 -> y=32'h80008000 (sign kept).
- Reset, then two back-to-back mode=2 transfers with x=16'h1234 -> y=32'h1234ACE1, then y=32'h12345670.
- out_ready=0, stream words A, B, C with in_valid=1:
  - A is in the output, B is in the skid, in_ready=0, C is held off.
  - Raise out_ready: A, B, C emerge in order, no duplicates.
  - in_ready returns to 1 one cycle after the skid drains.
- CE=0 for 3 cycles mid-stream with pending data -> in_ready=out_valid=0 at ports, y/LFSR unchanged; resumes identically when CE=1.
- Assert RESET=0 with both registers full -> next cycle out_valid=0, y=0, in_ready=1; the next dither output uses ACE1.

Source files
------------

// File: rtl/ux_dequant_expand_pipe.sv
// Re-expands a rounded signed word to full width by appending restored fraction bits
// (zero, half-LSB or LFSR dither), behind a valid/ready register stage with a skid buffer.
module ux_dequant_expand_pipe #(
  parameter int WordLength  = 32,
  parameter int RoundLength = 16
) (
  input  logic                                      CLK,
  input  logic                                      RESET,
  input  logic                                      CE,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic signed [WordLength-RoundLength-1:0]  x,
  input  logic        [1:0]                         mode,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic signed [WordLength-1:0]              y
);

  localparam int              XW        = WordLength - RoundLength;
  localparam logic [15:0]     LFSR_SEED = 16'hACE1;

  function automatic logic [RoundLength-1:0] fill_bits(input logic [1:0]  m,
                                                       input logic [15:0] l);
    logic [RoundLength-1:0] f;
    f = '0;
    case (m)
      2'd1:    f = {1'b1, {(RoundLength-1){1'b0}}};
      2'd2:    f = l[RoundLength-1:0];
      default: f = '0;
    endcase
    return f;
  endfunction

  // The narrowed word forms the upper bits untouched, so the sign carries over and no saturation exists.
  function automatic logic signed [WordLength-1:0] expand(input logic signed [XW-1:0]         xv,
                                                          input logic        [RoundLength-1:0] f);
    return $signed({xv, f});
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  logic [15:0]                   lfsr;
  logic                          vld_p1;
  logic signed [WordLength-1:0]  data_p1;
  logic                          skid_vld_p1;
  logic signed [WordLength-1:0]  skid_p1;

  logic                          in_xfer;
  logic                          out_free;
  logic signed [WordLength-1:0]  exp_p0;

  // Stage p0: expansion on the input side, dither taken from the pre-step LFSR value
  assign in_xfer  = CE & in_valid & ~skid_vld_p1;
  assign out_free = ~vld_p1 | out_ready;
  assign exp_p0   = expand(x, fill_bits(mode, lfsr));

  // Stage p1: output register plus one-deep skid; skid fills only while the output is stalled
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      vld_p1      <= 1'b0;
      data_p1     <= '0;
      skid_vld_p1 <= 1'b0;
      lfsr        <= LFSR_SEED;
    end else if (CE) begin
      if (in_xfer) begin
        lfsr <= lfsr_step(lfsr);
      end
      if (out_free) begin
        if (skid_vld_p1) begin
          data_p1     <= skid_p1;
          vld_p1      <= 1'b1;
          skid_vld_p1 <= 1'b0;
        end else if (in_xfer) begin
          data_p1 <= exp_p0;
          vld_p1  <= 1'b1;
        end else begin
          vld_p1 <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_vld_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CE && !out_free && in_xfer) begin
      skid_p1 <= exp_p0;
    end
  end

  assign in_ready  = CE & ~skid_vld_p1;
  assign out_valid = CE & vld_p1;
  assign y         = data_p1;

endmodule

// File: tb/tb_ux_dequant_expand_pipe.sv
// Scoreboard bench for ux_dequant_expand_pipe: directed scenarios followed by randomized traffic.
module tb_ux_dequant_expand_pipe;

  localparam int WL = 32;
  localparam int RL = 16;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic                 CE;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [WL-RL-1:0] x;
  logic [1:0]           mode;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [WL-1:0] y;

  ux_dequant_expand_pipe #(.WordLength(WL), .RoundLength(RL)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [15:0] mdl_lfsr = 16'hACE1;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_y = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: y = x * 2^RL + fill, fill chosen from the mode and the current dither state
  function automatic logic [31:0] model_expand(input logic signed [15:0] xv, input logic [1:0] m,
                                               input logic [15:0] l);
    longint      f;
    longint      e;
    logic [63:0] ev;
    f = 0;
    if (m == 2'd1) f = longint'(1) << (RL - 1);
    else if (m == 2'd2) f = longint'(l);
    e  = longint'(xv) * (longint'(1) << RL) + f;
    ev = e;
    return ev[31:0];
  endfunction

  function automatic logic [15:0] model_lfsr_next(input logic [15:0] l);
    logic fb;
    fb = ^(l & 16'h002D);
    return (l >> 1) | ({15'd0, fb} << 15);
  endfunction

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        hold_pend = 1'b0;
      end else begin
        if (out_valid && hold_pend) chk("hold_stable", y, hold_y);
        if (out_valid) hold_pend = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got %h expected none", y);
          end else begin
            e = exp_q.pop_front();
            chk("scoreboard", y, e);
          end
        end else if (out_valid) begin
          hold_pend = 1'b1;
          hold_y    = y;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model_expand(x, mode, mdl_lfsr));
          mdl_lfsr = model_lfsr_next(mdl_lfsr);
        end
      end
    end
  end

  task automatic xfer(input logic [15:0] xv, input logic [1:0] mv);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    x        = xv;
    mode     = mv;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    exp_q.delete();
    mdl_lfsr = 16'hACE1;
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  initial begin
    logic [31:0] ysav;
    CE = 1'b1; RESET = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; mode = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1;

    out_ready = 1'b1;
    xfer(16'h1234, 2'd0);
    @(negedge CLK);
    chk("zero_fill", y, 32'h12340000);
    chk("zero_fill_valid", {31'd0, out_valid}, 32'd1);
    chk("zero_fill_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge CLK); #1;
    xfer(16'h1234, 2'd1);
    @(negedge CLK);
    chk("midpoint", y, 32'h12348000);
    @(posedge CLK); #1;
    xfer(16'h8000, 2'd1);
    @(negedge CLK);
    chk("midpoint_neg", y, 32'h80008000);
    @(posedge CLK); #1;

    do_reset();
    xfer(16'h1234, 2'd2);
    xfer(16'h1234, 2'd2);
    @(negedge CLK);
    chk("dither_second", y, 32'h12345670);
    @(posedge CLK); #1;

    out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0; x = 16'h0A0A;
    @(posedge CLK); #1; x = 16'h0B0B;
    @(posedge CLK); #1; x = 16'h0C0C;
    @(negedge CLK);
    chk("skid_in_ready", {31'd0, in_ready}, 32'd0);
    chk("skid_head", y, 32'h0A0A0000);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("skid_still_full", {31'd0, in_ready}, 32'd0);
    @(posedge CLK); #1; out_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("skid_release", {31'd0, in_ready}, 32'd1);
    chk("skid_second", y, 32'h0B0B0000);
    @(posedge CLK); #1; in_valid = 1'b0;
    @(negedge CLK);
    chk("skid_third", y, 32'h0C0C0000);
    @(posedge CLK); #1;

    out_ready = 1'b0; in_valid = 1'b1; x = 16'h5555; mode = 2'd2;
    @(posedge CLK); #1;
    x = 16'h6666; CE = 1'b0; ysav = y;
    repeat (3) begin
      @(negedge CLK);
      chk("ce_in_ready", {31'd0, in_ready}, 32'd0);
      chk("ce_out_valid", {31'd0, out_valid}, 32'd0);
      chk("ce_y_held", y, ysav);
    end
    @(posedge CLK); #1; CE = 1'b1;
    @(posedge CLK); #1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0; x = 16'h1111;
    @(posedge CLK); #1; x = 16'h2222;
    @(posedge CLK); #1; in_valid = 1'b0;
    @(negedge CLK);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge CLK); #1;
    do_reset();
    @(negedge CLK);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_y", y, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge CLK); #1;
    out_ready = 1'b1;
    xfer(16'h1234, 2'd2);
    @(negedge CLK);
    chk("post_rst_dither", y, 32'h1234ACE1);
    @(posedge CLK); #1;

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      x         = 16'($urandom);
      mode      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 99) < 60);
      CE        = ($urandom_range(0, 99) < 88);
      @(posedge CLK); #1;
    end

    CE = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
